// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-source FIFOs for ALU/MEM/MUL results, round-robin
// selection of one head per cycle, presented as a registered ROB write.
module wb_arbiter #(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned ROB_ENTRY_WIDTH = 6,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       rob_hold,
  input  logic                       alu_valid,
  input  logic [ROB_ENTRY_WIDTH-1:0] alu_rob_id,
  input  logic [WORD_SIZE-1:0]       alu_data,
  input  logic                       mem_valid,
  input  logic [ROB_ENTRY_WIDTH-1:0] mem_rob_id,
  input  logic [WORD_SIZE-1:0]       mem_data,
  input  logic                       mul_valid,
  input  logic [ROB_ENTRY_WIDTH-1:0] mul_rob_id,
  input  logic [WORD_SIZE-1:0]       mul_data,
  output logic                       alu_stall,
  output logic                       mem_stall,
  output logic                       mul_stall,
  output logic                       rob_wr_en,
  output logic [ROB_ENTRY_WIDTH-1:0] rob_wr_id,
  output logic [WORD_SIZE-1:0]       rob_wr_data,
  output logic [1:0]                 rob_wr_src,
  output logic                       overflow_err
);

  localparam int unsigned NSRC = 3;
  localparam int unsigned EW   = ROB_ENTRY_WIDTH + WORD_SIZE;
  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW   = $clog2(DEPTH + 1);

  logic [NSRC-1:0]         in_valid;
  logic [NSRC-1:0]         stall;
  logic [NSRC-1:0]         nonempty;
  logic [NSRC-1:0][EW-1:0] in_entry;
  logic [NSRC-1:0][EW-1:0] head;
  logic [EW-1:0]           grant_entry;
  logic                    grant;
  logic [1:0]              grant_src;
  logic [1:0]              rr_ptr;
  logic [1:0]              rr_next;
  logic [2:0]              cand;

  assign in_valid    = {mul_valid, mem_valid, alu_valid};
  assign in_entry[0] = {alu_rob_id, alu_data};
  assign in_entry[1] = {mem_rob_id, mem_data};
  assign in_entry[2] = {mul_rob_id, mul_data};

  assign alu_stall = stall[0];
  assign mem_stall = stall[1];
  assign mul_stall = stall[2];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  for (genvar s = 0; s < NSRC; s++) begin : g_fifo
    logic [EW-1:0] store [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    // Stall is taken from the registered count only, so a same-cycle pop never frees a slot.
    assign stall[s]    = (count == CW'(DEPTH));
    assign nonempty[s] = (count != '0);
    assign head[s]     = store[rd_ptr];
    assign push        = in_valid[s] && !stall[s] && !flush;
    assign pop         = grant && (grant_src == 2'(s));

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= ptr_inc(wr_ptr);
        if (pop)  rd_ptr <= ptr_inc(rd_ptr);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (push) store[wr_ptr] <= in_entry[s];
    end
  end

  // Rotate the search to start at rr_ptr; first non-empty source wins.
  always_comb begin
    grant     = 1'b0;
    grant_src = '0;
    cand      = '0;
    if (!rob_hold && !flush) begin
      for (int unsigned k = 0; k < NSRC; k++) begin
        cand = {1'b0, rr_ptr} + 3'(k);
        if (cand >= 3'(NSRC)) cand = cand - 3'(NSRC);
        if (!grant && nonempty[cand[1:0]]) begin
          grant     = 1'b1;
          grant_src = cand[1:0];
        end
      end
    end
  end

  always_comb begin
    case (grant_src)
      2'd1:    grant_entry = head[1];
      2'd2:    grant_entry = head[2];
      default: grant_entry = head[0];
    endcase
    rr_next = (grant_src == 2'd2) ? 2'd0 : grant_src + 2'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr       <= '0;
      rob_wr_en    <= 1'b0;
      rob_wr_id    <= '0;
      rob_wr_data  <= '0;
      rob_wr_src   <= '0;
      overflow_err <= 1'b0;
    end else begin
      rob_wr_en <= grant;
      if (grant) begin
        {rob_wr_id, rob_wr_data} <= grant_entry;
        rob_wr_src               <= grant_src;
      end
      if (flush)      rr_ptr <= '0;
      else if (grant) rr_ptr <= rr_next;
      if (|(in_valid & stall)) overflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: latency, round-robin order, stall/overflow,
// flush and asynchronous reset behaviour with DEPTH=2.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, rob_hold;
  logic        alu_valid, mem_valid, mul_valid;
  logic [5:0]  alu_rob_id, mem_rob_id, mul_rob_id;
  logic [31:0] alu_data, mem_data, mul_data;
  logic        alu_stall, mem_stall, mul_stall;
  logic        rob_wr_en;
  logic [5:0]  rob_wr_id;
  logic [31:0] rob_wr_data;
  logic [1:0]  rob_wr_src;
  logic        overflow_err;

  int n_checks = 0;
  int n_fail   = 0;
  int mem_n, mul_n;

  wb_arbiter #(.WORD_SIZE(32), .ROB_ENTRY_WIDTH(6), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .rob_hold(rob_hold),
    .alu_valid(alu_valid), .alu_rob_id(alu_rob_id), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_rob_id(mem_rob_id), .mem_data(mem_data),
    .mul_valid(mul_valid), .mul_rob_id(mul_rob_id), .mul_data(mul_data),
    .alu_stall(alu_stall), .mem_stall(mem_stall), .mul_stall(mul_stall),
    .rob_wr_en(rob_wr_en), .rob_wr_id(rob_wr_id), .rob_wr_data(rob_wr_data),
    .rob_wr_src(rob_wr_src), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0; rob_hold = 1'b0;
    alu_valid = 1'b0; mem_valid = 1'b0; mul_valid = 1'b0;
    alu_rob_id = '0; mem_rob_id = '0; mul_rob_id = '0;
    alu_data = '0; mem_data = '0; mul_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    #2;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    idle_inputs();
    #3;
    check("rst_en", rob_wr_en, 0);
    check("rst_id", rob_wr_id, 0);
    check("rst_data", rob_wr_data, 0);
    check("rst_src", rob_wr_src, 0);
    check("rst_ovf", overflow_err, 0);
    check("rst_stalls", {alu_stall, mem_stall, mul_stall}, 0);
    @(negedge clk);
    rst = 1'b1;

    // 1: single ALU result, two-edge latency, one-cycle strobe
    alu_valid = 1'b1; alu_rob_id = 6'd5; alu_data = 32'hDEADBEEF;
    tick();
    idle_inputs();
    check("t1_en_e0", rob_wr_en, 0);
    tick();
    check("t1_en", rob_wr_en, 1);
    check("t1_id", rob_wr_id, 5);
    check("t1_data", rob_wr_data, 32'hDEADBEEF);
    check("t1_src", rob_wr_src, 0);
    tick();
    check("t1_en_off", rob_wr_en, 0);
    check("t1_id_hold", rob_wr_id, 5);

    // 2: all three push together from a fresh reset
    do_reset();
    alu_valid = 1'b1; alu_rob_id = 6'd1; alu_data = 32'h101;
    mem_valid = 1'b1; mem_rob_id = 6'd2; mem_data = 32'h202;
    mul_valid = 1'b1; mul_rob_id = 6'd3; mul_data = 32'h303;
    tick();
    idle_inputs();
    tick();
    check("t2_w0_en", rob_wr_en, 1);
    check("t2_w0", {rob_wr_src, rob_wr_id}, {2'd0, 6'd1});
    tick();
    check("t2_w1_en", rob_wr_en, 1);
    check("t2_w1", {rob_wr_src, rob_wr_id, rob_wr_data}, {2'd1, 6'd2, 32'h202});
    tick();
    check("t2_w2_en", rob_wr_en, 1);
    check("t2_w2", {rob_wr_src, rob_wr_id, rob_wr_data}, {2'd2, 6'd3, 32'h303});
    tick();
    check("t2_idle", rob_wr_en, 0);
    // rr_ptr back at 0: ALU wins over MEM
    alu_valid = 1'b1; alu_rob_id = 6'h0A;
    mem_valid = 1'b1; mem_rob_id = 6'h0B;
    tick();
    idle_inputs();
    tick();
    check("t2_rr_a", {rob_wr_en, rob_wr_src, rob_wr_id}, {1'b1, 2'd0, 6'h0A});
    tick();
    check("t2_rr_b", {rob_wr_en, rob_wr_src, rob_wr_id}, {1'b1, 2'd1, 6'h0B});

    // 3: MEM and MUL stream continuously, grants must alternate 1,2,1,2
    do_reset();
    mem_n = 0; mul_n = 0;
    for (int i = 0; i < 8; i++) begin
      mem_valid = !mem_stall; mem_rob_id = 6'(16 + mem_n); mem_data = 32'h1000 + 32'(mem_n);
      if (mem_valid) mem_n++;
      mul_valid = !mul_stall; mul_rob_id = 6'(32 + mul_n); mul_data = 32'h2000 + 32'(mul_n);
      if (mul_valid) mul_n++;
      tick();
      if (i >= 1) begin
        check("t3_en", rob_wr_en, 1);
        if (i % 2 == 1)
          check("t3_mem", {rob_wr_src, rob_wr_id}, {2'd1, 6'(16 + (i - 1) / 2)});
        else
          check("t3_mul", {rob_wr_src, rob_wr_id}, {2'd2, 6'(32 + (i - 2) / 2)});
      end
    end
    check("t3_ovf", overflow_err, 0);

    // 4: hold with ALU overfilled; third push dropped and flagged
    do_reset();
    rob_hold = 1'b1;
    alu_valid = 1'b1; alu_rob_id = 6'd7; alu_data = 32'h7;
    tick();
    check("t4_stall_1", alu_stall, 0);
    alu_rob_id = 6'd8; alu_data = 32'h8;
    tick();
    check("t4_stall_2", alu_stall, 1);
    check("t4_hold_en", rob_wr_en, 0);
    alu_rob_id = 6'd9; alu_data = 32'h9;
    tick();
    check("t4_ovf", overflow_err, 1);
    idle_inputs();
    tick();
    check("t4_w7", {rob_wr_en, rob_wr_id}, {1'b1, 6'd7});
    check("t4_stall_rel", alu_stall, 0);
    tick();
    check("t4_w8", {rob_wr_en, rob_wr_id}, {1'b1, 6'd8});
    tick();
    check("t4_no_w9", rob_wr_en, 0);

    // 5: flush drops queued entries and a same-cycle MEM push
    rob_hold = 1'b1;
    alu_valid = 1'b1; alu_rob_id = 6'h31;
    mul_valid = 1'b1; mul_rob_id = 6'h33;
    tick();
    mul_valid = 1'b0;
    alu_rob_id = 6'h32;
    tick();
    check("t5_alu_full", alu_stall, 1);
    alu_valid = 1'b0;
    flush = 1'b1;
    mem_valid = 1'b1; mem_rob_id = 6'h3F;
    tick();
    idle_inputs();
    check("t5_stalls", {alu_stall, mem_stall, mul_stall}, 0);
    check("t5_en", rob_wr_en, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_no_write", rob_wr_en, 0);
    end
    check("t5_ovf_kept", overflow_err, 1);
    mem_valid = 1'b1; mem_rob_id = 6'h2A;
    tick();
    idle_inputs();
    check("t5_new_e0", rob_wr_en, 0);
    tick();
    check("t5_new", {rob_wr_en, rob_wr_src, rob_wr_id}, {1'b1, 2'd1, 6'h2A});

    // 6: asynchronous reset mid-burst
    rob_hold = 1'b1;
    alu_valid = 1'b1; alu_rob_id = 6'h11;
    mem_valid = 1'b1; mem_rob_id = 6'h12;
    tick();
    mem_valid = 1'b0;
    alu_rob_id = 6'h13;
    tick();
    idle_inputs();
    check("t6_pre_stall", alu_stall, 1);
    tick();
    check("t6_pre_en", rob_wr_en, 1);
    #2;
    rst = 1'b0;
    #1;
    check("t6_en", rob_wr_en, 0);
    check("t6_stalls", {alu_stall, mem_stall, mul_stall}, 0);
    check("t6_id", rob_wr_id, 0);
    check("t6_ovf", overflow_err, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t6_no_stale", rob_wr_en, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
